// File: rtl/player_pkg.sv
// Shared state encoding and keyboard decoding for the player sprite controller.
package player_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    INVULN,
    DEAD
  } state_t;

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;

  // A key counts as pressed if either of the two reported keycodes matches.
  function automatic logic key_hit(input logic [15:0] keycode, input logic [7:0] key);
    return (keycode[15:8] == key) || (keycode[7:0] == key);
  endfunction

endpackage

// File: rtl/aabb_hit.sv
// Combinational overlap test between the player box (centre, radius R) and one enemy box.
module aabb_hit #(
  parameter int R = 4
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] ex,
  input  logic [9:0] ey,
  input  logic [9:0] es,
  input  logic       valid,
  output logic       hit
);

  logic [10:0] p_left, p_right, p_top, p_bot, e_right, e_bot;

  // 11-bit sums; the clamp keeps the player centre at least R from zero.
  assign p_left  = {1'b0, px} - 11'(R);
  assign p_right = {1'b0, px} + 11'(R);
  assign p_top   = {1'b0, py} - 11'(R);
  assign p_bot   = {1'b0, py} + 11'(R);
  assign e_right = {1'b0, ex} + {1'b0, es};
  assign e_bot   = {1'b0, ey} + {1'b0, es};

  assign hit = valid && (p_left <= e_right) && (p_top <= e_bot) &&
               (p_right > {1'b0, ex}) && (p_bot > {1'b0, ey});

endmodule

// File: rtl/player_ctrl.sv
// Per-frame player movement, enemy collision and lives/invulnerability/game-over FSM.
module player_ctrl
  import player_pkg::*;
#(
  parameter int SIZE          = 8,
  parameter int STEP          = 3,
  parameter int N_ENEMY       = 4,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int X_MIN         = 3,
  parameter int X_MAX         = 636,
  parameter int Y_MIN         = 3,
  parameter int Y_MAX         = 476,
  parameter int X_CENTER      = 320,
  parameter int Y_CENTER      = 240
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [15:0]            keycode,
  input  logic [10*N_ENEMY-1:0]  enemy_x,
  input  logic [10*N_ENEMY-1:0]  enemy_y,
  input  logic [10*N_ENEMY-1:0]  enemy_size,
  input  logic [N_ENEMY-1:0]     enemy_valid,
  output logic [9:0]             player_x,
  output logic [9:0]             player_y,
  output logic [9:0]             player_s,
  output logic [2:0]             lives,
  output logic                   hit_pulse,
  output logic                   invuln,
  output logic                   game_over
);

  localparam int R = SIZE / 2;
  localparam int CNT_W = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [9:0] X_LO = 10'(X_MIN + R);
  localparam logic [9:0] X_HI = 10'(X_MAX - R);
  localparam logic [9:0] Y_LO = 10'(Y_MIN + R);
  localparam logic [9:0] Y_HI = 10'(Y_MAX - R);
  localparam logic [9:0] X_C  = 10'(X_CENTER);
  localparam logic [9:0] Y_C  = 10'(Y_CENTER);

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [2:0]        lives_q, lives_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_pulse_q, hit_pulse_d;
  logic              invuln_q, invuln_d;
  logic              game_over_q, game_over_d;
  logic [N_ENEMY-1:0] ch_hit;
  logic              hit;
  logic [9:0]        x_mv, y_mv;

  // Opposing keys cancel; the result saturates at the bounds instead of wrapping.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dec,
                                           input logic inc, input logic [9:0] lo,
                                           input logic [9:0] hi);
    logic [11:0] p;
    p = {2'b00, pos};
    if (inc && !dec) p = p + 12'(STEP);
    else if (dec && !inc) p = (p < 12'(lo) + 12'(STEP)) ? 12'(lo) : p - 12'(STEP);
    if (p > 12'(hi)) p = 12'(hi);
    if (p < 12'(lo)) p = 12'(lo);
    return 10'(p);
  endfunction

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_enemy
    aabb_hit #(.R(R)) u_aabb (
      .px    (x_q),
      .py    (y_q),
      .ex    (enemy_x[10*i +: 10]),
      .ey    (enemy_y[10*i +: 10]),
      .es    (enemy_size[10*i +: 10]),
      .valid (enemy_valid[i]),
      .hit   (ch_hit[i])
    );
  end

  assign hit  = |ch_hit;
  assign x_mv = step_axis(x_q, key_hit(keycode, KEY_A), key_hit(keycode, KEY_D), X_LO, X_HI);
  assign y_mv = step_axis(y_q, key_hit(keycode, KEY_W), key_hit(keycode, KEY_S), Y_LO, Y_HI);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    lives_d     = lives_q;
    cnt_d       = cnt_q;
    hit_pulse_d = 1'b0;
    case (state_q)
      ALIVE: begin
        if (hit) begin
          lives_d     = lives_q - 3'd1;
          hit_pulse_d = 1'b1;
          x_d         = X_C;
          y_d         = Y_C;
          if (lives_d == 3'd0) begin
            state_d = DEAD;
          end else begin
            state_d = INVULN;
            cnt_d   = CNT_W'(INVULN_FRAMES - 1);
          end
        end else begin
          x_d = x_mv;
          y_d = y_mv;
        end
      end
      INVULN: begin
        x_d = x_mv;
        y_d = y_mv;
        if (cnt_q == '0) state_d = ALIVE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      DEAD: begin
        x_d = X_C;
        y_d = Y_C;
      end
      default: state_d = ALIVE;
    endcase
    invuln_d    = (state_d == INVULN);
    game_over_d = (state_d == DEAD);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ALIVE;
      x_q         <= X_C;
      y_q         <= Y_C;
      lives_q     <= 3'(LIVES);
      cnt_q       <= '0;
      hit_pulse_q <= 1'b0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      hit_pulse_q <= hit_pulse_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign player_x  = x_q;
  assign player_y  = y_q;
  assign player_s  = 10'(SIZE);
  assign lives     = lives_q;
  assign hit_pulse = hit_pulse_q;
  assign invuln    = invuln_q;
  assign game_over = game_over_q;

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Parametrised player-sprite controller for the meteorite-dodge game, clocked once per video frame. It moves the player from two-key USB keycodes, checks collision against N enemy boxes, and runs a lives/invulnerability/game-over state machine. Position and size feed the sprite renderer; status outputs feed the HUD and the game-level FSM.

## Interface
- SIZE, 8: player box edge in pixels; radius R = SIZE/2.
- STEP, 3: pixels moved per frame per axis.
- N_ENEMY, 4: number of enemy collision channels.
- LIVES, 3: lives at reset, 1..7.
- INVULN_FRAMES, 60: frames of collision immunity after a non-fatal hit, ≥1.
- X_MIN/X_MAX/Y_MIN/Y_MAX, 3/636/3/476: playfield bounds.
- X_CENTER/Y_CENTER, 320/240: spawn point.
- frame_clk  in  1  frame clock, the only clock.
- Reset  in  1  synchronous, active-high.
- keycode  in  16  two 8-bit keycodes, [15:8] and [7:0].
- enemy_x, enemy_y, enemy_size  in  10*N_ENEMY each  packed per channel; channel i is bits [10i+9:10i].
- enemy_valid  in  N_ENEMY  channel i participates in collision.
- player_x, player_y  out  10  player centre.
- player_s  out  10  constant SIZE.
- lives  out  3  remaining lives.
- hit_pulse  out  1  one-frame pulse per life lost.
- invuln  out  1  high while in INVULN.
- game_over  out  1  high in DEAD.

## Operation
- Keys: A=8'h04 (−x), D=8'h07 (+x), W=8'h1A (−y), S=8'h16 (+y). A key is active if either keycode byte matches it.
- Axes are independent, so diagonals are allowed. A+D together gives no x motion; W+S together gives no y motion.
- Next position is pos ± STEP, clamped to [X_MIN+R, X_MAX−R] and [Y_MIN+R, Y_MAX−R]. A clamped position stops at the bound and never wraps.
- Collision on channel i: enemy_valid[i] && px−R ≤ ex+es && py−R ≤ ey+es && px+R > ex && py+R > ey.
  - Evaluated on the registered position.
  - All sums use 11-bit unsigned arithmetic; px−R cannot underflow because of the clamp.
- hit = OR of all channels. Several channels in the same frame count as one hit.
- States:
  - ALIVE: movement enabled.
    - On hit: lives−1, hit_pulse=1, position set to centre.
    - If the new lives value is 0, go to DEAD; otherwise go to INVULN with cnt=INVULN_FRAMES−1.
  - INVULN: movement enabled, hit ignored, cnt decrements each frame. Go to ALIVE on the frame after cnt==0.
  - DEAD: position frozen at centre, keys ignored. Only Reset leaves DEAD.
- Hit has priority over movement in the same frame: position goes to centre, not pos±STEP.
- Reset (any state, any frame): ALIVE, pos=(X_CENTER,Y_CENTER), lives=LIVES, cnt=0, hit_pulse=0, invuln=0, game_over=0.

## Timing
- All outputs are registered.
- Key held at edge k: position changes at edge k (motion is combinational from keycode, no extra motion register).
- Overlap present during frame k: at edge k+1, hit_pulse=1, lives updated, position=centre, invuln or game_over set. hit_pulse clears at edge k+2.
- INVULN lasts exactly INVULN_FRAMES frames; invuln is high for INVULN_FRAMES cycles.
- Reset is sampled on the frame_clk edge and overrides every other event at that edge.

## Structure
- Package player_pkg holds:
  - state_t enum {ALIVE, INVULN, DEAD}.
  - Key constants KEY_A, KEY_D, KEY_W, KEY_S.
  - Function key_hit(keycode, key).
- Sub-module aabb_hit: combinational box-overlap check for one channel, instantiated N_ENEMY times in a generate loop.
- The top level holds the FSM, position registers, clamp logic, lives counter and invulnerability counter.

## Test plan
- Reset, hold D (keycode 16'h0007) for 10 frames → player_x=350, player_y=240.
- Hold A+W (16'h041A) from reset for 200 frames → x clamps to 7, y clamps to 7, with no wrap.
- Enemy 2 valid at (318,238) size 4, others invalid → one frame later: hit_pulse=1, lives=2, invuln=1, pos=(320,240).
  - Enemy held in place for INVULN_FRAMES → no further hit.
  - Return to ALIVE on the next frame.
- Two channels overlapping in the same frame → lives drops by exactly 1.
- Three spaced hits → lives=0, game_over=1, keys ignored, position held. Reset → lives=3, game_over=0.
- Reset asserted mid-INVULN (cnt=30) → next frame ALIVE, invuln=0, cnt=0, lives=3.
